axi_lp_quiesce: RTL and testbench

- Parametrised low-power and traffic-quiesce controller for one AXI3 master/slave link carrying the csysreq/csysack/cactive sideband.
- Gates the AW and AR address handshakes between master side (s_) and slave side (m_).
- Monitors the W/B/R handshakes to count outstanding write and read transactions.
- Admits low-power entry only once the link is fully drained. Sits inline on the address channels; the data and response channels pass around it untouched.

---
 rtl/axi_lp_quiesce.sv | 161 ++++++++++++++++
 tb/tb_axi_lp_quiesce.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axi_lp_quiesce.sv
// AXI3 low-power quiesce controller: gates AW/AR on outstanding limits and csysreq,
// counts outstanding transactions, and runs the csysreq/csysack/cactive handshake.
module axi_lp_quiesce #(
    parameter int  MAX_WR_OUTST = 8,
    parameter int  MAX_RD_OUTST = 8,
    parameter int  IDLE_HOLD    = 4,
    localparam int WCNT_W       = $clog2(MAX_WR_OUTST + 1),
    localparam int RCNT_W       = $clog2(MAX_RD_OUTST + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_awvalid,
    output logic              s_awready,
    output logic              m_awvalid,
    input  logic              m_awready,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic              wvalid,
    input  logic              wready,
    input  logic              wlast,
    input  logic              bvalid,
    input  logic              bready,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  logic              csysreq,
    output logic              csysack,
    output logic              cactive,
    output logic [WCNT_W-1:0] wr_outst,
    output logic [RCNT_W-1:0] rd_outst,
    output logic              proto_err
);

    localparam int ICNT_W = $clog2(IDLE_HOLD + 1);
    localparam logic [WCNT_W-1:0] WR_MAX   = WCNT_W'(MAX_WR_OUTST);
    localparam logic [RCNT_W-1:0] RD_MAX   = RCNT_W'(MAX_RD_OUTST);
    localparam logic [ICNT_W-1:0] IDLE_LIM = ICNT_W'(IDLE_HOLD);
    localparam logic [ICNT_W-1:0] HOLD_M1  = ICNT_W'(IDLE_HOLD - 1);

    typedef enum logic [1:0] {RUN, DRAIN, LOWPWR, WAKE} state_t;

    state_t              state_q;
    logic                csysack_q;
    logic                cactive_q;
    logic                proto_err_q;
    logic                aw_pend_q, aw_pend_d;
    logic                ar_pend_q, ar_pend_d;
    logic [WCNT_W-1:0]   wr_outst_q, wr_outst_d;
    logic [RCNT_W-1:0]   rd_outst_q, rd_outst_d;
    logic [ICNT_W-1:0]   idle_cnt_q;
    logic                aw_open, ar_open;
    logic                aw_hs, ar_hs, b_hs, r_done;
    logic                wr_err, rd_err;
    logic                idle;

    // A pending address stays open so a valid already shown to the slave is never retracted.
    assign aw_open   = aw_pend_q | ((state_q == RUN) & (wr_outst_q < WR_MAX));
    assign ar_open   = ar_pend_q | ((state_q == RUN) & (rd_outst_q < RD_MAX));
    assign m_awvalid = s_awvalid & aw_open;
    assign s_awready = m_awready & aw_open;
    assign m_arvalid = s_arvalid & ar_open;
    assign s_arready = m_arready & ar_open;

    assign aw_hs  = m_awvalid & m_awready;
    assign ar_hs  = m_arvalid & m_arready;
    assign b_hs   = bvalid & bready;
    assign r_done = rvalid & rready & rlast;

    assign aw_pend_d = (aw_pend_q | (m_awvalid & ~m_awready)) & ~aw_hs;
    assign ar_pend_d = (ar_pend_q | (m_arvalid & ~m_arready)) & ~ar_hs;

    assign idle = (wr_outst_q == '0) & (rd_outst_q == '0) & ~s_awvalid & ~s_arvalid &
                  ~wvalid & ~aw_pend_q & ~ar_pend_q;

    always_comb begin
        wr_outst_d = wr_outst_q;
        wr_err     = 1'b0;
        if (aw_hs && !b_hs) begin
            if (wr_outst_q == WR_MAX) wr_err = 1'b1;
            else                      wr_outst_d = wr_outst_q + WCNT_W'(1);
        end else if (b_hs && !aw_hs) begin
            if (wr_outst_q == '0)     wr_err = 1'b1;
            else                      wr_outst_d = wr_outst_q - WCNT_W'(1);
        end
    end

    always_comb begin
        rd_outst_d = rd_outst_q;
        rd_err     = 1'b0;
        if (ar_hs && !r_done) begin
            if (rd_outst_q == RD_MAX) rd_err = 1'b1;
            else                      rd_outst_d = rd_outst_q + RCNT_W'(1);
        end else if (r_done && !ar_hs) begin
            if (rd_outst_q == '0)     rd_err = 1'b1;
            else                      rd_outst_d = rd_outst_q - RCNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            csysack_q   <= 1'b1;
            cactive_q   <= 1'b1;
            proto_err_q <= 1'b0;
            aw_pend_q   <= 1'b0;
            ar_pend_q   <= 1'b0;
            wr_outst_q  <= '0;
            rd_outst_q  <= '0;
            idle_cnt_q  <= '0;
        end else begin
            aw_pend_q   <= aw_pend_d;
            ar_pend_q   <= ar_pend_d;
            wr_outst_q  <= wr_outst_d;
            rd_outst_q  <= rd_outst_d;
            proto_err_q <= proto_err_q | wr_err | rd_err | ((state_q == DRAIN) & csysreq);
            case (state_q)
                RUN: begin
                    if (!csysreq) begin
                        state_q    <= DRAIN;
                        cactive_q  <= 1'b1;
                        idle_cnt_q <= '0;
                    end else begin
                        cactive_q  <= (idle_cnt_q < HOLD_M1) | ~idle;
                        if (!idle)                      idle_cnt_q <= '0;
                        else if (idle_cnt_q != IDLE_LIM) idle_cnt_q <= idle_cnt_q + ICNT_W'(1);
                    end
                end
                DRAIN: begin
                    // A withdrawn request wins over a simultaneous drain completion.
                    if (csysreq) begin
                        state_q <= RUN;
                    end else if (idle) begin
                        state_q   <= LOWPWR;
                        csysack_q <= 1'b0;
                        cactive_q <= 1'b0;
                    end
                end
                LOWPWR: begin
                    if (csysreq) begin
                        state_q   <= WAKE;
                        csysack_q <= 1'b1;
                    end
                end
                WAKE: begin
                    state_q   <= RUN;
                    cactive_q <= 1'b1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign csysack   = csysack_q;
    assign cactive   = cactive_q;
    assign wr_outst  = wr_outst_q;
    assign rd_outst  = rd_outst_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_lp_quiesce.sv
// Directed bench for axi_lp_quiesce: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_axi_lp_quiesce;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_awvalid, s_awready, m_awvalid, m_awready;
    logic       s_arvalid, s_arready, m_arvalid, m_arready;
    logic       wvalid, wready, wlast, bvalid, bready, rvalid, rready, rlast;
    logic       csysreq, csysack, cactive, proto_err;
    logic [3:0] wr_outst, rd_outst;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    axi_lp_quiesce #(.MAX_WR_OUTST(8), .MAX_RD_OUTST(8), .IDLE_HOLD(4)) dut (
        .clock(clock), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .bvalid(bvalid), .bready(bready),
        .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .csysreq(csysreq), .csysack(csysack), .cactive(cactive),
        .wr_outst(wr_outst), .rd_outst(rd_outst), .proto_err(proto_err)
    );

    task automatic test_reset();
        #2;
        n_cmp++; if (csysack !== 1'b1) begin n_err++; $display("FAIL reset_csysack: got %b want 1", csysack); end
        n_cmp++; if (cactive !== 1'b1) begin n_err++; $display("FAIL reset_cactive: got %b want 1", cactive); end
        n_cmp++; if (wr_outst !== 4'd0) begin n_err++; $display("FAIL reset_wr_outst: got %0d want 0", wr_outst); end
        n_cmp++; if (rd_outst !== 4'd0) begin n_err++; $display("FAIL reset_rd_outst: got %0d want 0", rd_outst); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_awvalid: got %b want 0", m_awvalid); end
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_aw_limit();
        @(negedge clock); s_awvalid = 1'b1; m_awready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_cmp++;
            if (wr_outst !== 4'(i) || s_awready !== 1'b1) begin
                n_err++; $display("FAIL aw_fill_%0d: got wr_outst=%0d s_awready=%b want %0d/1", i, wr_outst, s_awready, i);
            end
            @(negedge clock);
        end
        #1;
        n_cmp++; if (wr_outst !== 4'd8) begin n_err++; $display("FAIL aw_full_cnt: got %0d want 8", wr_outst); end
        n_cmp++; if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin n_err++; $display("FAIL aw_full_gate: got s_awready=%b m_awvalid=%b want 0/0", s_awready, m_awvalid); end
        bvalid = 1'b1; bready = 1'b1;
        @(negedge clock); bvalid = 1'b0; bready = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd7) begin n_err++; $display("FAIL aw_b_dec: got %0d want 7", wr_outst); end
        n_cmp++; if (s_awready !== 1'b1 || m_awvalid !== 1'b1) begin n_err++; $display("FAIL aw_reopen: got s_awready=%b m_awvalid=%b want 1/1", s_awready, m_awvalid); end
        @(negedge clock); s_awvalid = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd8) begin n_err++; $display("FAIL aw_ninth: got %0d want 8", wr_outst); end
        bvalid = 1'b1; bready = 1'b1;
        repeat (8) @(negedge clock);
        bvalid = 1'b0; bready = 1'b0; m_awready = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd0 || proto_err !== 1'b0) begin n_err++; $display("FAIL aw_drain: got wr_outst=%0d proto_err=%b want 0/0", wr_outst, proto_err); end
    endtask

    task automatic test_rd_same_cycle();
        @(negedge clock); s_arvalid = 1'b1; m_arready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++; if (rd_outst !== 4'd3) begin n_err++; $display("FAIL rd_fill: got %0d want 3", rd_outst); end
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if (rd_outst !== 4'd3) begin n_err++; $display("FAIL rd_same_cycle: got %0d want 3", rd_outst); end
        s_arvalid = 1'b0; rlast = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (rd_outst !== 4'd3) begin n_err++; $display("FAIL rd_not_last: got %0d want 3", rd_outst); end
        rlast = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if (rd_outst !== 4'd2) begin n_err++; $display("FAIL rd_last_dec: got %0d want 2", rd_outst); end
        repeat (2) @(negedge clock);
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; m_arready = 1'b0; #1;
        n_cmp++; if (rd_outst !== 4'd0 || proto_err !== 1'b0) begin n_err++; $display("FAIL rd_drain: got rd_outst=%0d proto_err=%b want 0/0", rd_outst, proto_err); end
    endtask

    task automatic test_pending_drain();
        @(negedge clock); s_awvalid = 1'b1; m_awready = 1'b0; #1;
        n_cmp++; if (m_awvalid !== 1'b1 || s_awready !== 1'b0) begin n_err++; $display("FAIL pend_present: got m_awvalid=%b s_awready=%b want 1/0", m_awvalid, s_awready); end
        @(negedge clock); csysreq = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (m_awvalid !== 1'b1) begin n_err++; $display("FAIL pend_hold_drain: got m_awvalid=%b want 1", m_awvalid); end
        m_awready = 1'b1; #1;
        n_cmp++; if (s_awready !== 1'b1) begin n_err++; $display("FAIL pend_accept: got s_awready=%b want 1", s_awready); end
        @(negedge clock); s_awvalid = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd1) begin n_err++; $display("FAIL pend_count: got %0d want 1", wr_outst); end
        n_cmp++; if (s_awready !== 1'b0) begin n_err++; $display("FAIL drain_closed: got s_awready=%b want 0", s_awready); end
        n_cmp++; if (csysack !== 1'b1) begin n_err++; $display("FAIL drain_ack_busy: got %b want 1", csysack); end
        bvalid = 1'b1; bready = 1'b1;
        @(negedge clock); bvalid = 1'b0; bready = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd0 || csysack !== 1'b1) begin n_err++; $display("FAIL drain_b: got wr_outst=%0d csysack=%b want 0/1", wr_outst, csysack); end
        @(negedge clock); #1;
        n_cmp++; if (csysack !== 1'b0 || cactive !== 1'b0) begin n_err++; $display("FAIL drain_enter_lp: got csysack=%b cactive=%b want 0/0", csysack, cactive); end
        s_awvalid = 1'b1; #1;
        n_cmp++; if (s_awready !== 1'b0 || m_awvalid !== 1'b0) begin n_err++; $display("FAIL lp_holdoff: got s_awready=%b m_awvalid=%b want 0/0", s_awready, m_awvalid); end
        @(negedge clock); #1;
        n_cmp++; if (cactive !== 1'b0 || csysack !== 1'b0) begin n_err++; $display("FAIL lp_stay: got cactive=%b csysack=%b want 0/0", cactive, csysack); end
        s_awvalid = 1'b0; m_awready = 1'b0; csysreq = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_lowpower();
        @(negedge clock); csysreq = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (csysack !== 1'b1) begin n_err++; $display("FAIL lp_t1: got csysack=%b want 1", csysack); end
        @(negedge clock); #1;
        n_cmp++; if (csysack !== 1'b0 || cactive !== 1'b0) begin n_err++; $display("FAIL lp_t2: got csysack=%b cactive=%b want 0/0", csysack, cactive); end
        @(negedge clock); csysreq = 1'b1; m_awready = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if (csysack !== 1'b1 || cactive !== 1'b0 || s_awready !== 1'b0) begin n_err++; $display("FAIL wake_u1: got csysack=%b cactive=%b s_awready=%b want 1/0/0", csysack, cactive, s_awready); end
        @(negedge clock); #1;
        n_cmp++; if (cactive !== 1'b1 || s_awready !== 1'b1) begin n_err++; $display("FAIL wake_u2: got cactive=%b s_awready=%b want 1/1", cactive, s_awready); end
        m_awready = 1'b0;
    endtask

    task automatic test_idle_hold();
        logic exp_c;
        @(negedge clock); s_arvalid = 1'b1; m_arready = 1'b1;
        @(negedge clock); s_arvalid = 1'b0; m_arready = 1'b0; rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(negedge clock); rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_c = (i < 4);
            #1;
            n_cmp++; if (cactive !== exp_c) begin n_err++; $display("FAIL idle_hold_t%0d: got cactive=%b want %b", i, cactive, exp_c); end
            @(negedge clock);
        end
        s_arvalid = 1'b1; m_arready = 1'b1; #1;
        n_cmp++; if (cactive !== 1'b0) begin n_err++; $display("FAIL idle_t6: got cactive=%b want 0", cactive); end
        @(negedge clock); s_arvalid = 1'b0; m_arready = 1'b0; #1;
        n_cmp++; if (cactive !== 1'b1 || rd_outst !== 4'd1) begin n_err++; $display("FAIL idle_t7: got cactive=%b rd_outst=%0d want 1/1", cactive, rd_outst); end
        rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
        @(negedge clock); rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_proto_err();
        @(negedge clock); bvalid = 1'b1; bready = 1'b1;
        @(negedge clock); bvalid = 1'b0; bready = 1'b0; #1;
        n_cmp++; if (proto_err !== 1'b1 || wr_outst !== 4'd0) begin n_err++; $display("FAIL underflow: got proto_err=%b wr_outst=%0d want 1/0", proto_err, wr_outst); end
        @(negedge clock); #1;
        n_cmp++; if (proto_err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", proto_err); end
        s_awvalid = 1'b1; m_awready = 1'b1;
        repeat (5) @(negedge clock);
        s_awvalid = 1'b0; #1;
        n_cmp++; if (wr_outst !== 4'd5) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 5", wr_outst); end
        csysreq = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1; #1;
        n_cmp++; if (wr_outst !== 4'd0 || proto_err !== 1'b0) begin n_err++; $display("FAIL async_reset: got wr_outst=%0d proto_err=%b want 0/0", wr_outst, proto_err); end
        n_cmp++; if (csysack !== 1'b1 || cactive !== 1'b1 || s_awready !== 1'b1) begin n_err++; $display("FAIL async_reset_ctl: got csysack=%b cactive=%b s_awready=%b want 1/1/1", csysack, cactive, s_awready); end
        csysreq = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_abort();
        @(negedge clock); wvalid = 1'b1; csysreq = 1'b0;
        @(negedge clock); #1;
        n_cmp++; if (csysack !== 1'b1 || s_awready !== 1'b0) begin n_err++; $display("FAIL abort_drain: got csysack=%b s_awready=%b want 1/0", csysack, s_awready); end
        csysreq = 1'b1;
        @(negedge clock); #1;
        n_cmp++; if (proto_err !== 1'b1 || csysack !== 1'b1 || s_awready !== 1'b1) begin n_err++; $display("FAIL abort_run: got proto_err=%b csysack=%b s_awready=%b want 1/1/1", proto_err, csysack, s_awready); end
        wvalid = 1'b0; m_awready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        s_awvalid = 1'b0; m_awready = 1'b0; s_arvalid = 1'b0; m_arready = 1'b0;
        wvalid = 1'b0; wready = 1'b0; wlast = 1'b0; bvalid = 1'b0; bready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; csysreq = 1'b1;
        test_reset();
        test_aw_limit();
        test_rd_same_cycle();
        test_pending_drain();
        test_lowpower();
        test_idle_hold();
        test_proto_err();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
